trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl.sv | 163 ++++++++++++++++
 tb/tb_trap_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Trap/interrupt sequencer: on ecall, ebreak or an enabled external interrupt it
// writes mepc, mcause and mstatus through the CSR commit port, then redirects the PC to mtvec. On mret it restores mstatus and redirects the PC to mepc.
//
// state       | meaning
// ------------+---------------------------------------------
// IDLE        | waiting for an event; detect cycle stalls the pipe
// W_MEPC      | commit epc to MEPC
// W_MCAUSE    | commit cause to MCAUSE
// W_MSTATUS   | commit mstatus with MPIE<=MIE, MIE<=0
// ASSERT      | redirect to mtvec
// R_MSTATUS   | mret: commit mstatus with MIE<=MPIE, MPIE<=1
// R_ASSERT    | mret: redirect to mepc
module trap_ctrl (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic        ext_int_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        global_int_en_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        hold_o,
  output logic        commit_wen_o,
  output logic [31:0] commit_waddr_o,
  output logic [31:0] commit_wdata_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MTVEC   = 32'h0000_0305;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

  localparam logic [31:0] CAUSE_ECALL   = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
  localparam logic [31:0] CAUSE_EXT_INT = 32'h8000_000B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MCAUSE,
    S_W_MSTATUS,
    S_ASSERT,
    S_R_MSTATUS,
    S_R_ASSERT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] mstatus_q, mstatus_d;
  logic        hold_c;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cause_q   <= '0;
      epc_q     <= '0;
      mstatus_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      mstatus_q <= mstatus_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cause_d        = cause_q;
    epc_d          = epc_q;
    mstatus_d      = mstatus_q;
    hold_c         = 1'b0;
    commit_wen_o   = 1'b0;
    commit_waddr_o = '0;
    commit_wdata_o = '0;
    int_assert_o   = 1'b0;
    int_addr_o     = '0;

    unique case (state_q)
      S_IDLE: begin
        if (ecall_i) begin
          hold_c    = 1'b1;
          cause_d   = CAUSE_ECALL;
          epc_d     = inst_addr_i;
          mstatus_d = csr_mstatus_i;
          state_d   = S_W_MEPC;
        end else if (ebreak_i) begin
          hold_c    = 1'b1;
          cause_d   = CAUSE_EBREAK;
          epc_d     = inst_addr_i;
          mstatus_d = csr_mstatus_i;
          state_d   = S_W_MEPC;
        end else if (mret_i) begin
          hold_c    = 1'b1;
          mstatus_d = csr_mstatus_i;
          state_d   = S_R_MSTATUS;
        end else if (ext_int_i && global_int_en_i) begin
          // A taken jump in execute means the interrupted flow resumes at its target
          hold_c    = 1'b1;
          cause_d   = CAUSE_EXT_INT;
          epc_d     = jump_flag_i ? jump_addr_i : inst_addr_i;
          mstatus_d = csr_mstatus_i;
          state_d   = S_W_MEPC;
        end
      end
      S_W_MEPC: begin
        hold_c         = 1'b1;
        commit_wen_o   = 1'b1;
        commit_waddr_o = CSR_MEPC;
        commit_wdata_o = epc_q;
        state_d        = S_W_MCAUSE;
      end
      S_W_MCAUSE: begin
        hold_c         = 1'b1;
        commit_wen_o   = 1'b1;
        commit_waddr_o = CSR_MCAUSE;
        commit_wdata_o = cause_q;
        state_d        = S_W_MSTATUS;
      end
      S_W_MSTATUS: begin
        hold_c         = 1'b1;
        commit_wen_o   = 1'b1;
        commit_waddr_o = CSR_MSTATUS;
        commit_wdata_o = {mstatus_q[31:8], mstatus_q[3], mstatus_q[6:4], 1'b0, mstatus_q[2:0]};
        state_d        = S_ASSERT;
      end
      S_ASSERT: begin
        hold_c       = 1'b1;
        int_assert_o = 1'b1;
        int_addr_o   = csr_mtvec_i;
        state_d      = S_IDLE;
      end
      S_R_MSTATUS: begin
        hold_c         = 1'b1;
        commit_wen_o   = 1'b1;
        commit_waddr_o = CSR_MSTATUS;
        commit_wdata_o = {mstatus_q[31:8], 1'b1, mstatus_q[6:4], mstatus_q[7], mstatus_q[2:0]};
        state_d        = S_R_ASSERT;
      end
      S_R_ASSERT: begin
        hold_c       = 1'b1;
        int_assert_o = 1'b1;
        int_addr_o   = csr_mepc_i;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The detect-cycle stall is combinational from the inputs, so mask it during reset
  assign hold_o = hold_c & rstn;

  logic unused_mtvec_addr;
  assign unused_mtvec_addr = ^CSR_MTVEC;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: per-cycle vector table plus a hand-written
// reset-abort sequence.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ecall, ebreak, mret, ext_int, jump_flag, gie;
  logic [31:0] inst_addr, jump_addr, mtvec, mepc, mstatus;
  logic        hold, wen, ia;
  logic [31:0] waddr, wdata, iaddr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  trap_ctrl dut (
    .clk             (clk),
    .rstn            (rstn),
    .ecall_i         (ecall),
    .ebreak_i        (ebreak),
    .mret_i          (mret),
    .ext_int_i       (ext_int),
    .inst_addr_i     (inst_addr),
    .jump_flag_i     (jump_flag),
    .jump_addr_i     (jump_addr),
    .global_int_en_i (gie),
    .csr_mtvec_i     (mtvec),
    .csr_mepc_i      (mepc),
    .csr_mstatus_i   (mstatus),
    .hold_o          (hold),
    .commit_wen_o    (wen),
    .commit_waddr_o  (waddr),
    .commit_wdata_o  (wdata),
    .int_assert_o    (ia),
    .int_addr_o      (iaddr)
  );

  typedef struct {
    logic [4:0]  ev;   // {ecall, ebreak, mret, ext_int, gie}
    logic        jf;
    logic [31:0] inst, jaddr, mtvec, mepc, mst;
    logic        hold, wen;
    logic [31:0] waddr, wdata;
    logic        ia;
    logic [31:0] iaddr;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] MT = 32'h2C4;

  function automatic vec_t mk(input logic [4:0] ev, input logic jf,
                              input logic [31:0] inst, input logic [31:0] jaddr,
                              input logic [31:0] mtv, input logic [31:0] mep,
                              input logic [31:0] mst, input logic h, input logic w,
                              input logic [31:0] wa, input logic [31:0] wd,
                              input logic a, input logic [31:0] aa);
    vec_t v;
    v.ev = ev; v.jf = jf; v.inst = inst; v.jaddr = jaddr; v.mtvec = mtv;
    v.mepc = mep; v.mst = mst; v.hold = h; v.wen = w; v.waddr = wa;
    v.wdata = wd; v.ia = a; v.iaddr = aa;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic h, input logic w,
                         input logic [31:0] wa, input logic [31:0] wd,
                         input logic a, input logic [31:0] aa);
    chk({tag, ".hold"},  {31'd0, hold}, {31'd0, h});
    chk({tag, ".wen"},   {31'd0, wen},  {31'd0, w});
    chk({tag, ".waddr"}, waddr, wa);
    chk({tag, ".wdata"}, wdata, wd);
    chk({tag, ".ia"},    {31'd0, ia},   {31'd0, a});
    chk({tag, ".iaddr"}, iaddr, aa);
  endtask

  task automatic drive(input logic [4:0] ev, input logic jf, input logic [31:0] ins,
                       input logic [31:0] ja, input logic [31:0] mtv,
                       input logic [31:0] mep, input logic [31:0] mst);
    {ecall, ebreak, mret, ext_int, gie} = ev;
    jump_flag = jf; inst_addr = ins; jump_addr = ja;
    mtvec = mtv; mepc = mep; mstatus = mst;
  endtask

  initial begin
    // ecall at 0x100, ebreak pulse ignored during W_MCAUSE, mstatus input changes mid-sequence
    vecs.push_back(mk(5'b00000, 0, 0,      0, MT, 32'h104, 0,       0, 0, 0,      0,      0, 0));
    vecs.push_back(mk(5'b10000, 0, 32'h100,0, MT, 32'h104, 32'h88,  1, 0, 0,      0,      0, 0));
    vecs.push_back(mk(5'b00000, 0, 0,      0, MT, 32'h104, 32'h88,  1, 1, 32'h341,32'h100,0, 0));
    vecs.push_back(mk(5'b01000, 0, 32'h180,0, MT, 32'h104, 32'h88,  1, 1, 32'h342,32'd11, 0, 0));
    vecs.push_back(mk(5'b00000, 0, 0,      0, MT, 32'h104, 0,       1, 1, 32'h300,32'h80, 0, 0));
    vecs.push_back(mk(5'b00000, 0, 0,      0, MT, 32'h104, 0,       1, 0, 0,      0,      1, MT));
    vecs.push_back(mk(5'b00000, 0, 0,      0, MT, 32'h104, 0,       0, 0, 0,      0,      0, 0));
    // ext_int masked by MIE=0, then taken with a jump in execute
    vecs.push_back(mk(5'b00010, 0, 32'h1F0,0, MT, 32'h104, 32'h08,  0, 0, 0,      0,      0, 0));
    vecs.push_back(mk(5'b00011, 1, 32'h1F0,32'h200, MT, 32'h104, 32'h08, 1, 0, 0, 0,      0, 0));
    vecs.push_back(mk(5'b00000, 0, 0,      0, MT, 32'h104, 0,       1, 1, 32'h341,32'h200,0, 0));
    vecs.push_back(mk(5'b00000, 0, 0,      0, MT, 32'h104, 0,       1, 1, 32'h342,32'h8000000B,0,0));
    vecs.push_back(mk(5'b00000, 0, 0,      0, MT, 32'h104, 0,       1, 1, 32'h300,32'h80, 0, 0));
    vecs.push_back(mk(5'b00000, 0, 0,      0, 32'h400, 32'h104, 0,  1, 0, 0,      0,      1, 32'h400));
    // mret accepted in the cycle right after ASSERT
    vecs.push_back(mk(5'b00100, 0, 0,      0, MT, 32'h104, 32'h80,  1, 0, 0,      0,      0, 0));
    vecs.push_back(mk(5'b00000, 0, 0,      0, MT, 32'h104, 0,       1, 1, 32'h300,32'h88, 0, 0));
    vecs.push_back(mk(5'b00000, 0, 0,      0, MT, 32'h104, 0,       1, 0, 0,      0,      1, 32'h104));
    // ecall + ebreak + ext_int together: ecall wins
    vecs.push_back(mk(5'b11011, 0, 32'h300,0, MT, 32'h104, 0,       1, 0, 0,      0,      0, 0));
    vecs.push_back(mk(5'b00000, 0, 0,      0, MT, 32'h104, 0,       1, 1, 32'h341,32'h300,0, 0));
    vecs.push_back(mk(5'b00000, 0, 0,      0, MT, 32'h104, 0,       1, 1, 32'h342,32'd11, 0, 0));
    vecs.push_back(mk(5'b00000, 0, 0,      0, MT, 32'h104, 0,       1, 1, 32'h300,0,      0, 0));
    vecs.push_back(mk(5'b00000, 0, 0,      0, MT, 32'h104, 0,       1, 0, 0,      0,      1, MT));
    // level ext_int held throughout: ignored mid-sequence, re-taken on return to IDLE
    vecs.push_back(mk(5'b00011, 0, 32'h500,32'h999, MT, 32'h104, 32'hFFFFFF7F, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(5'b00011, 0, 32'h504,0, MT, 32'h104, 0,       1, 1, 32'h341,32'h500,0, 0));
    vecs.push_back(mk(5'b00011, 0, 32'h504,0, MT, 32'h104, 0,       1, 1, 32'h342,32'h8000000B,0,0));
    vecs.push_back(mk(5'b00011, 0, 32'h504,0, MT, 32'h104, 0,       1, 1, 32'h300,32'hFFFFFFF7,0,0));
    vecs.push_back(mk(5'b00011, 0, 32'h504,0, MT, 32'h104, 0,       1, 0, 0,      0,      1, MT));
    vecs.push_back(mk(5'b00011, 0, 32'h508,0, MT, 32'h104, 0,       1, 0, 0,      0,      0, 0));
    vecs.push_back(mk(5'b00000, 0, 0,      0, MT, 32'h104, 0,       1, 1, 32'h341,32'h508,0, 0));
    vecs.push_back(mk(5'b00000, 0, 0,      0, MT, 32'h104, 0,       1, 1, 32'h342,32'h8000000B,0,0));
    vecs.push_back(mk(5'b00000, 0, 0,      0, MT, 32'h104, 0,       1, 1, 32'h300,0,      0, 0));
    vecs.push_back(mk(5'b00000, 0, 0,      0, MT, 32'h104, 0,       1, 0, 0,      0,      1, MT));
    // mret with MPIE=0 then redirect to a changed mepc
    vecs.push_back(mk(5'b00100, 0, 0,      0, MT, 32'h104, 32'h08,  1, 0, 0,      0,      0, 0));
    vecs.push_back(mk(5'b00000, 0, 0,      0, MT, 32'h104, 0,       1, 1, 32'h300,32'h80, 0, 0));
    vecs.push_back(mk(5'b00000, 0, 0,      0, MT, 32'h108, 0,       1, 0, 0,      0,      1, 32'h108));
    vecs.push_back(mk(5'b00000, 0, 0,      0, MT, 32'h108, 0,       0, 0, 0,      0,      0, 0));

    // reset with an event present: hold must stay low
    rstn = 1'b0;
    drive(5'b10000, 0, 32'h100, 0, MT, 32'h104, 32'h88);
    #12;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(5'b00000, 0, 0, 0, MT, 32'h104, 0);
    rstn = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].ev, vecs[i].jf, vecs[i].inst, vecs[i].jaddr,
            vecs[i].mtvec, vecs[i].mepc, vecs[i].mst);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].hold, vecs[i].wen, vecs[i].waddr,
              vecs[i].wdata, vecs[i].ia, vecs[i].iaddr);
    end

    // reset asserted during W_MCAUSE abandons the sequence
    @(negedge clk);
    drive(5'b10000, 0, 32'h100, 0, MT, 32'h104, 32'h88);
    #1 chk_all("rst_seq.detect", 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(5'b00000, 0, 0, 0, MT, 32'h104, 0);
    #1 chk_all("rst_seq.mepc", 1, 1, 32'h341, 32'h100, 0, 0);
    @(negedge clk);
    #1 chk_all("rst_seq.mcause", 1, 1, 32'h342, 32'd11, 0, 0);
    rstn = 1'b0;
    #1 chk_all("rst_seq.async", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1 chk_all("rst_seq.held", 0, 0, 0, 0, 0, 0);
    rstn = 1'b1;
    @(negedge clk);
    #1 chk_all("rst_seq.no_mstatus", 0, 0, 0, 0, 0, 0);

    // fresh ebreak sequence after release
    @(negedge clk);
    drive(5'b01000, 0, 32'h700, 0, MT, 32'h104, 32'h08);
    #1 chk_all("ebrk.detect", 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(5'b00000, 0, 0, 0, MT, 32'h104, 0);
    #1 chk_all("ebrk.mepc", 1, 1, 32'h341, 32'h700, 0, 0);
    @(negedge clk);
    #1 chk_all("ebrk.mcause", 1, 1, 32'h342, 32'd3, 0, 0);
    @(negedge clk);
    #1 chk_all("ebrk.mstatus", 1, 1, 32'h300, 32'h80, 0, 0);
    @(negedge clk);
    #1 chk_all("ebrk.assert", 1, 0, 0, 0, 1, MT);
    @(negedge clk);
    #1 chk_all("ebrk.idle", 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
